// File: rtl/apb_slave_regbank.sv
// APB completer with a bank of 32-bit R/W registers and a sticky protocol-error flag.
// Latency: Pready rises WAIT_STATES+1 cycles after the setup cycle; all responses are registered.
// Backpressure: holds Pready low for WAIT_STATES access cycles; an early drop of sel/Penable aborts.
module apb_slave_regbank #(
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0,
    parameter int SEL_BIT     = 0
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic        proto_err,
    output logic [15:0] xfer_count
);

    typedef enum logic [1:0] {IDLE, ACCESS_WAIT, ACCESS_DONE} state_t;

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_STATES);
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    state_t      state_q, state_d;
    logic [5:0]  addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] regs_q [16];
    logic [31:0] regs_d [16];
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic        proto_err_q, proto_err_d;
    logic [15:0] xfer_count_q, xfer_count_d;

    logic sel, setup, access, take_setup;
    logic unused_inputs;

    assign sel    = Pselx[SEL_BIT];
    assign setup  = sel & ~Penable;
    assign access = sel & Penable;

    // Only the word index and alignment bits matter; the rest of the bus is decoded upstream.
    assign unused_inputs = ^{Paddr[31:6], Pselx};

    function automatic logic addr_bad(input logic [5:0] a);
        return (a[1:0] != 2'b00) || ({1'b0, a[5:2]} >= NUM_REGS_W);
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        wcnt_d       = wcnt_q;
        regs_d       = regs_q;
        prdata_d     = prdata_q;
        proto_err_d  = proto_err_q;
        xfer_count_d = xfer_count_q;
        take_setup   = 1'b0;

        case (state_q)
            IDLE: begin
                if (access) begin
                    proto_err_d = 1'b1;
                end else if (setup) begin
                    take_setup = 1'b1;
                end
            end
            ACCESS_WAIT: begin
                if (access) begin
                    wcnt_d = wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) begin
                        state_d = ACCESS_DONE;
                    end
                end else begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                    take_setup  = setup;
                end
            end
            ACCESS_DONE: begin
                if (access) begin
                    state_d      = IDLE;
                    xfer_count_d = xfer_count_q + 16'd1;
                    if (write_q && !addr_bad(addr_q)) begin
                        regs_d[addr_q[5:2]] = wdata_q;
                    end
                end else begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                    take_setup  = setup;
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_setup) begin
            addr_d  = Paddr[5:0];
            write_d = Pwrite;
            wdata_d = Pwdata;
            wcnt_d  = WAIT_INIT;
            state_d = (WAIT_STATES == 0) ? ACCESS_DONE : ACCESS_WAIT;
        end

        // Response is computed one cycle ahead so every APB output comes straight from a flop.
        pready_d  = (state_d == ACCESS_DONE);
        pslverr_d = pready_d && addr_bad(addr_d);
        if (pready_d) begin
            prdata_d = addr_bad(addr_d) ? 32'h0 : regs_q[addr_d[5:2]];
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            wcnt_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
            prdata_q     <= '0;
            pready_q     <= 1'b0;
            pslverr_q    <= 1'b0;
            proto_err_q  <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            wcnt_q       <= wcnt_d;
            regs_q       <= regs_d;
            prdata_q     <= prdata_d;
            pready_q     <= pready_d;
            pslverr_q    <= pslverr_d;
            proto_err_q  <= proto_err_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign Prdata     = prdata_q;
    assign Pready     = pready_q;
    assign Pslverr    = pslverr_q;
    assign proto_err  = proto_err_q;
    assign xfer_count = xfer_count_q;

endmodule
